// File: rtl/alu_74181_nibble_seq.sv
// Drives one shared 74181 slice across a WIDTH-bit operation, one nibble per clock, LSB first.
// The slice carry is chained between nibbles; result, carry and A=B are assembled and held.
`timescale 1ns/1ps
module alu_74181_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       sel_i,
  input  logic             mode_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             aeqb_o,
  output logic [3:0]       alu_S_o,
  output logic             alu_M_o,
  output logic             alu_carry_o,
  output logic [3:0]       alu_A_o,
  output logic [3:0]       alu_B_o,
  input  logic [3:0]       alu_F_i,
  input  logic             alu_carry_i,
  input  logic             alu_aeqb_i
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("alu_74181_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [3:0]       sel_reg;
  logic             mode_reg;
  logic             carry_run;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             aeqb_acc;
  logic             aeqb_next;

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // Slice inputs are forced to zero outside RUN so the shared slice sees a quiet bus.
  always_comb begin
    alu_S_o     = 4'd0;
    alu_M_o     = 1'b0;
    alu_carry_o = 1'b0;
    alu_A_o     = 4'd0;
    alu_B_o     = 4'd0;
    if (state == RUN) begin
      alu_S_o     = sel_reg;
      alu_M_o     = mode_reg;
      alu_carry_o = carry_run;
      alu_A_o     = a_reg[4*int'(idx) +: 4];
      alu_B_o     = b_reg[4*int'(idx) +: 4];
    end
  end

  always_comb begin
    acc_next = acc;
    acc_next[4*int'(idx) +: 4] = alu_F_i;
    aeqb_next = aeqb_acc & alu_aeqb_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      sel_reg   <= 4'd0;
      mode_reg  <= 1'b0;
      carry_run <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      aeqb_acc  <= 1'b0;
      result_o  <= '0;
      carry_o   <= 1'b0;
      aeqb_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            sel_reg   <= sel_i;
            mode_reg  <= mode_i;
            carry_run <= carry_i;
            a_reg     <= a_i;
            b_reg     <= b_i;
            acc       <= '0;
            aeqb_acc  <= 1'b1;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc       <= acc_next;
          carry_run <= alu_carry_i;
          aeqb_acc  <= aeqb_next;
          // Published outputs change only on the edge that enters DONE.
          if (idx == LAST) begin
            result_o <= acc_next;
            carry_o  <= alu_carry_i;
            aeqb_o   <= aeqb_next;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_74181_nibble_seq.sv
// Self-checking bench: a behavioural 74181 slice sits on the alu_* bus and whole-word
// results are predicted from the 74181 function table.
`timescale 1ns/1ps
module tb_alu_74181_nibble_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       sel;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             aeqb;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_cin;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_f;
  logic             alu_cout;
  logic             alu_eq;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_74181_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_i(rst), .start_i(start), .sel_i(sel), .mode_i(mode),
    .carry_i(cin), .a_i(a), .b_i(b), .busy_o(busy), .done_o(done),
    .result_o(result), .carry_o(cout), .aeqb_o(aeqb),
    .alu_S_o(alu_s), .alu_M_o(alu_m), .alu_carry_o(alu_cin),
    .alu_A_o(alu_a), .alu_B_o(alu_b),
    .alu_F_i(alu_f), .alu_carry_i(alu_cout), .alu_aeqb_i(alu_eq)
  );

  // 4-bit 74181 slice, active-high data and carry, gate-level style.
  always_comb begin
    logic [3:0] x, y, f;
    logic [4:0] s;
    x = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    s = {1'b0, x} + {1'b0, y} + {4'd0, alu_cin};
    f = alu_m ? ~(x ^ y) : s[3:0];
    alu_f    = f;
    alu_cout = s[4];
    alu_eq   = (f == 4'hF);
  end

  // Whole-word prediction straight from the datasheet function table.
  function automatic void ref_model(input logic [3:0] s, input logic m, input logic c,
                                    input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] r, output logic co, output logic eq);
    logic [15:0] p, q;
    logic [16:0] sum;
    case (s)
      4'b0000: begin p = x;       q = 16'h0;    end
      4'b0001: begin p = x | y;   q = 16'h0;    end
      4'b0010: begin p = x | ~y;  q = 16'h0;    end
      4'b0011: begin p = 16'hFFFF; q = 16'h0;   end
      4'b0100: begin p = x;       q = x & ~y;   end
      4'b0101: begin p = x | y;   q = x & ~y;   end
      4'b0110: begin p = x;       q = ~y;       end
      4'b0111: begin p = x & ~y;  q = 16'hFFFF; end
      4'b1000: begin p = x;       q = x & y;    end
      4'b1001: begin p = x;       q = y;        end
      4'b1010: begin p = x | ~y;  q = x & y;    end
      4'b1011: begin p = x & y;   q = 16'hFFFF; end
      4'b1100: begin p = x;       q = x;        end
      4'b1101: begin p = x | y;   q = x;        end
      4'b1110: begin p = x | ~y;  q = x;        end
      default: begin p = x;       q = 16'hFFFF; end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {16'd0, c};
    co  = sum[16];
    case (s)
      4'b0000: r = ~x;
      4'b0001: r = ~(x | y);
      4'b0010: r = ~x & y;
      4'b0011: r = 16'h0000;
      4'b0100: r = ~(x & y);
      4'b0101: r = ~y;
      4'b0110: r = x ^ y;
      4'b0111: r = x & ~y;
      4'b1000: r = ~x | y;
      4'b1001: r = ~(x ^ y);
      4'b1010: r = y;
      4'b1011: r = x & y;
      4'b1100: r = 16'hFFFF;
      4'b1101: r = x | ~y;
      4'b1110: r = x | y;
      default: r = x;
    endcase
    if (!m) r = sum[15:0];
    eq = (r == 16'hFFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic c,
                        input logic [15:0] ai, input logic [15:0] bi, input bit chk_nib);
    logic [15:0] er;
    logic        ec, eeq;
    int          lat;
    ref_model(s, m, c, ai, bi, er, ec, eeq);
    sel = s; mode = m; cin = c; a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      if (chk_nib && k < NIB) check($sformatf("%s_alu_A%0d", tag, k), 32'(alu_a), 32'(ai[4*k +: 4]));
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NIB));
    check({tag, "_result"}, 32'(result), 32'(er));
    if (!m) check({tag, "_carry"}, 32'(cout), 32'(ec));
    check({tag, "_aeqb"}, 32'(aeqb), 32'(eeq));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    $display("op %s S=%b M=%b c=%b A=%h B=%h -> F=%h co=%b eq=%b lat=%0d",
             tag, s, m, c, ai, bi, result, cout, aeqb, lat);
  endtask

  initial begin
    int done_at[$];
    int seen;
    rst = 1'b1; start = 1'b0; sel = 4'd0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    check("reset_outputs", 32'({busy, done, cout, aeqb, result}), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op("add",  4'b1001, 1'b0, 1'b0, 16'h12FF, 16'h0001, 1'b1);
    // Asynchronous reset mid-cycle must clear held outputs without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_reset", 32'({busy, done, cout, aeqb, result}), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op("wrap", 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    run_op("xor",  4'b0110, 1'b1, 1'b0, 16'hA5C3, 16'h0FF0, 1'b0);
    run_op("cmp_eq", 4'b0110, 1'b0, 1'b0, 16'h3C3C, 16'h3C3C, 1'b0);
    run_op("cmp_ne", 4'b0110, 1'b0, 1'b0, 16'h3C3D, 16'h3C3C, 1'b0);

    // Held start: two operations, six clocks apart, one-cycle done pulses.
    sel = 4'b1001; mode = 1'b0; cin = 1'b0; a = 16'h0101; b = 16'h0202; start = 1'b1;
    seen = 0;
    for (int e = 0; e < 22; e++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(e);
        check($sformatf("hold_result%0d", seen), 32'(result), 32'h0303);
        seen++;
      end
      if (e == 9) start = 1'b0;
    end
    check("hold_op_count", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check("hold_first_done", 32'(done_at[0]), 32'd4);
      check("hold_spacing", 32'(done_at[1] - done_at[0]), 32'd6);
    end
    $display("op hold start: done pulses=%0d", done_at.size());

    // Reset during RUN discards the operation.
    sel = 4'b1001; mode = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrun_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset", 32'({busy, done, alu_a, result}), 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrun_no_done", 32'(seen), 32'd0);
    $display("op midrun reset: done pulses after reset=%0d", seen);

    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 4'($urandom), 1'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom), (i % 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
